// File: rtl/t01_ai_pkg.sv
// rtl/t01_ai_pkg.sv - shared types and constants for the t01 AI layer sequencer
package t01_ai_pkg;

    localparam int ACT_W      = 8;
    localparam int RES_W      = 18;
    localparam int L0_INPUTS  = 4;
    localparam int NUM_LAYERS = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_STREAM,
        S_COLLECT,
        S_FINISH
    } state_t;

endpackage

// File: rtl/t01_ai_requant.sv
// rtl/t01_ai_requant.sv - combinational 18-bit to signed 8-bit requantizer
// Round-half-up is enabled by defining T01_AI_REQUANT_ROUND_EN; otherwise truncating shift.
module t01_ai_requant
    import t01_ai_pkg::*;
#(
    parameter int SHIFT = 8
) (
    input  logic [RES_W-1:0] i_res,
    output logic [ACT_W-1:0] o_act
);

    localparam logic signed [RES_W:0] SAT_MAX = 127;
    localparam logic signed [RES_W:0] SAT_MIN = -128;
`ifdef T01_AI_REQUANT_ROUND_EN
    localparam logic signed [RES_W:0] ROUND_ADD = (RES_W + 1)'(1) << (SHIFT - 1);
`endif

    logic signed [RES_W:0] w_ext;
    logic signed [RES_W:0] w_sum;
    logic signed [RES_W:0] w_shr;

    // One extra bit of headroom keeps the rounding add from overflowing.
    always_comb begin
        w_ext = {i_res[RES_W-1], i_res};
`ifdef T01_AI_REQUANT_ROUND_EN
        w_sum = w_ext + ROUND_ADD;
`else
        w_sum = w_ext;
`endif
        w_shr = w_sum >>> SHIFT;
        if (w_shr > SAT_MAX) begin
            o_act = 8'h7f;
        end else if (w_shr < SAT_MIN) begin
            o_act = 8'h80;
        end else begin
            o_act = w_shr[ACT_W-1:0];
        end
    end

endmodule

// File: rtl/t01_ai_layer_seq.sv
// rtl/t01_ai_layer_seq.sv - four-layer MMU sequencer with ping-pong activation banks
// Requantization rounding follows T01_AI_REQUANT_ROUND_EN (see t01_ai_requant).
module t01_ai_layer_seq
    import t01_ai_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int SHIFT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_infer,
    input  logic             feat_valid,
    input  logic [ACT_W-1:0] feat_in,
    output logic             feat_ready,
    output logic             mmu_start,
    output logic [1:0]       mmu_layer_sel,
    output logic             mmu_act_valid,
    output logic [ACT_W-1:0] mmu_act_in,
    input  logic             mmu_res_valid,
    input  logic [RES_W-1:0] mmu_res_out,
    input  logic             mmu_done,
    output logic             busy,
    output logic             out_valid,
    output logic [RES_W-1:0] out_score,
    output logic             err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1) + 1;

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_layer;
    logic [CNT_W-1:0] r_cnt;
    logic [ACT_W-1:0] r_bank [2][DEPTH];
    logic [RES_W-1:0] r_first_res;
    logic             r_feat_ready;
    logic             r_mmu_start;
    logic             r_act_valid;
    logic [ACT_W-1:0] r_act_in;
    logic             r_busy;
    logic             r_out_valid;
    logic [RES_W-1:0] r_out_score;
    logic             r_err;

    logic             w_last_layer;
    logic             w_feat_acc;
    logic             w_beat_acc;
    logic             w_beat_drop;
    logic             w_count_bad;
    logic [CNT_W-1:0] w_n_last;
    logic [CNT_W-1:0] w_m_exp;
    logic [CNT_W-1:0] w_rcv_total;
    logic [IDX_W-1:0] w_rd_idx;
    logic             w_rd_sel;
    logic             w_wr_sel;
    logic [ACT_W-1:0] w_q;
    logic [RES_W-1:0] w_score;

    t01_ai_requant #(
        .SHIFT (SHIFT)
    ) u_requant (
        .i_res (mmu_res_out),
        .o_act (w_q)
    );

    assign w_last_layer = (r_layer == 2'(NUM_LAYERS - 1));
    assign w_n_last     = (r_layer == 2'd0) ? CNT_W'(L0_INPUTS - 1) : CNT_W'(DEPTH - 1);
    assign w_m_exp      = w_last_layer ? CNT_W'(1) : CNT_W'(DEPTH);
    assign w_feat_acc   = (r_state == S_LOAD) && feat_valid && r_feat_ready;
    assign w_beat_acc   = (r_state == S_COLLECT) && mmu_res_valid && (r_cnt < w_m_exp);
    assign w_beat_drop  = (r_state == S_COLLECT) && mmu_res_valid && (r_cnt >= w_m_exp);
    // A beat arriving with mmu_done is counted before the count is judged.
    assign w_rcv_total  = r_cnt + CNT_W'(w_beat_acc);
    assign w_count_bad  = (r_state == S_COLLECT) && mmu_done && (w_rcv_total != w_m_exp);
    assign w_rd_sel     = r_layer[0];
    assign w_wr_sel     = ~r_layer[0];
    assign w_rd_idx     = (r_state == S_STREAM) ? IDX_W'(r_cnt + CNT_W'(1)) : '0;
    assign w_score      = (r_cnt != '0) ? r_first_res : (w_beat_acc ? mmu_res_out : '0);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start_infer) w_next = S_LOAD;
            S_LOAD:    if (w_feat_acc && (r_cnt == CNT_W'(L0_INPUTS - 1))) w_next = S_START;
            S_START:   w_next = S_STREAM;
            S_STREAM:  if (r_cnt == w_n_last) w_next = S_COLLECT;
            S_COLLECT: if (mmu_done) w_next = w_last_layer ? S_FINISH : S_START;
            S_FINISH:  w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_layer      <= 2'd0;
            r_cnt        <= '0;
            r_first_res  <= '0;
            r_feat_ready <= 1'b0;
            r_mmu_start  <= 1'b0;
            r_act_valid  <= 1'b0;
            r_act_in     <= '0;
            r_busy       <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_score  <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_feat_ready <= (w_next == S_LOAD);
            r_mmu_start  <= (w_next == S_START);
            r_act_valid  <= (w_next == S_STREAM);
            r_act_in     <= (w_next == S_STREAM) ? r_bank[w_rd_sel][w_rd_idx] : '0;
            r_busy       <= (w_next != S_IDLE);
            r_out_valid  <= (w_next == S_FINISH);
            if (w_next == S_FINISH) begin
                r_out_score <= w_score;
            end
            if (w_beat_drop || w_count_bad) begin
                r_err <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start_infer) begin
                        r_layer <= 2'd0;
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (w_feat_acc) r_cnt <= r_cnt + CNT_W'(1);
                end
                S_START: begin
                    r_cnt <= '0;
                end
                S_STREAM: begin
                    r_cnt <= (r_cnt == w_n_last) ? '0 : r_cnt + CNT_W'(1);
                end
                S_COLLECT: begin
                    if (w_beat_acc && (r_cnt == '0)) r_first_res <= mmu_res_out;
                    if (mmu_done) begin
                        r_cnt <= '0;
                        if (!w_last_layer) r_layer <= r_layer + 2'd1;
                    end else if (w_beat_acc) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Activation storage carries no reset; contents are rewritten before every use.
    always_ff @(posedge clk) begin
        if (w_feat_acc) begin
            r_bank[0][r_cnt[IDX_W-1:0]] <= feat_in;
        end else if (w_beat_acc && !w_last_layer) begin
            r_bank[w_wr_sel][r_cnt[IDX_W-1:0]] <= w_q;
        end
    end

    assign feat_ready    = r_feat_ready;
    assign mmu_start     = r_mmu_start;
    assign mmu_layer_sel = r_layer;
    assign mmu_act_valid = r_act_valid;
    assign mmu_act_in    = r_act_in;
    assign busy          = r_busy;
    assign out_valid     = r_out_valid;
    assign out_score     = r_out_score;
    assign err           = r_err;

endmodule

// File: doc/t01_ai_layer_seq.md
# t01_ai_layer_seq

Layer sequencer and activation buffer around the MMU. It accepts 4 input features and drives layers 0–3 in order. For each layer it pulses the MMU start, streams the layer's input activations, then collects the layer's 18-bit results. Each result is requantized to signed 8 bits and stored in a ping-pong buffer that feeds the next layer. The single layer-3 result is returned raw as the inference score.

## Interface
Parameters:
- DEPTH, 32, activations per hidden layer (buffer bank depth)
- SHIFT, 8, requantization right-shift amount (1..16)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, reset is synchronous and active-low
- start_infer  in  1  begin inference; sampled only in IDLE
- feat_valid  in  1  input feature beat
- feat_in  in  8  signed input feature
- feat_ready  out  1  high in LOAD
- mmu_start  out  1  one-cycle MMU start pulse
- mmu_layer_sel  out  2  current layer
- mmu_act_valid  out  1  activation beat to MMU
- mmu_act_in  out  8  activation to MMU
- mmu_res_valid  in  1  MMU result beat
- mmu_res_out  in  18  signed MMU result
- mmu_done  in  1  MMU layer complete
- busy  out  1  high in every state except IDLE
- out_valid  out  1  one-cycle score pulse
- out_score  out  18  raw layer-3 result
- err  out  1  sticky beat-count error; cleared by reset or an accepted start_infer

## Operation
- States: IDLE → LOAD → START → STREAM → COLLECT → (START for the next layer | FINISH) → IDLE.
- **IDLE**
  - start_infer=1 → LOAD, layer=0, err cleared.
  - start_infer is ignored in every other state.
- **LOAD**
  - Writes feat_in into bank A entries 0..3 on feat_valid&feat_ready.
  - Moves to START after the 4th beat.
- **START**
  - mmu_start=1 for exactly one cycle with mmu_layer_sel=layer.
- **STREAM**
  - Input count N is 4 for layer 0 and DEPTH for layers 1–3.
  - Reads the read bank entries 0..N-1 in order.
  - mmu_act_valid is high for N consecutive cycles.
- **COLLECT**
  - Expected result count M is DEPTH for layers 0–2 and 1 for layer 3.
  - For layers 0–2, each mmu_res_valid beat is requantized and written to write-bank entry k, where k counts 0..M-1.
  - Beats beyond M are dropped and set err.
  - On mmu_done: if the received count is not M, err is set.
  - On mmu_done for layers 0–2: swap banks, increment layer, go to START.
  - On mmu_done for layer 3: go to FINISH.
  - A beat and mmu_done in the same cycle: the beat is counted first.
- **FINISH**
  - out_valid=1 for one cycle, out_score=first layer-3 beat (0 if none arrived); then IDLE.
- Requantization:
  - Sign-extend to 19 bits.
  - Add 2^(SHIFT-1) (rounding, see Configuration).
  - Arithmetic right shift by SHIFT.
  - Saturate to [-128, 127].
- Bank A holds features and layer-1 outputs... banks alternate strictly. Layer L reads bank (L mod 2) and writes bank ((L+1) mod 2).
- Reset mid-operation: the next clock edge with rst_n=0 returns to IDLE with all outputs at reset values. Buffer contents are don't-care.

## Timing
- Reset values:
  - mmu_start, mmu_act_valid, out_valid, busy, feat_ready, err: 0.
  - mmu_layer_sel: 0.
  - mmu_act_in: 0.
  - out_score: 0.
- All outputs are registered.
- Layer start:
  - mmu_start in cycle t.
  - First mmu_act_valid in cycle t+1, last in t+N.
  - mmu_act_valid is 0 at t+N+1.
- mmu_done observed at cycle t drives the next mmu_start at t+1; there are no idle gaps otherwise.
- Layer-3 mmu_done at cycle t drives out_valid at t+1 and busy=0 at t+2.
- mmu_layer_sel is stable from START until mmu_done for that layer.
- mmu_act_in is 0 whenever mmu_act_valid=0.

## Configuration
- T01_AI_REQUANT_ROUND_EN
  - Defined: round-half-up (add 2^(SHIFT-1) before the shift).
  - Undefined: plain truncating arithmetic shift, with no adder.
  - Saturation is unaffected in both cases.

## Structure
- Shared package t01_ai_pkg provides:
  - the state enum;
  - constants L0_INPUTS=4 and NUM_LAYERS=4;
  - widths ACT_W=8 and RES_W=18.
- Sub-module t01_ai_requant is combinational: 18-bit in → 8-bit out, parameterised by SHIFT. It holds the macro-guarded rounding.
- The two banks are DEPTH×8 register arrays inside the sequencer.

## Test plan
- **Feature streaming:** load features 1,2,3,4 → mmu_start pulse with layer_sel=0, then mmu_act_in 1,2,3,4 on 4 consecutive cycles.
- **Requantization (SHIFT=8):**
  - res_out 384 → 2 with rounding, 1 without.
  - 0x1FFFF → 127.
  - 0x3FF00 (−256) → −1.
  - 0x20000 → −128.
- **Full inference with a model MMU returning res_out=k·256 for beat k:**
  - Layer-1 stream carries 0,1,…,31.
  - Layer-3 beat 0x00abc → out_valid one cycle with out_score=0x00abc.
  - err=0 throughout.
- **Count errors:**
  - 31 beats then mmu_done on layer 0 → err=1, sequencing continues to layer 1.
  - 2 beats on layer 3 → err=1, out_score=first beat.
- **Reset and ignored start:**
  - rst_n=0 for one cycle during layer-2 STREAM → all outputs 0 next cycle, busy=0.
  - start_infer during COLLECT is ignored; layer_sel is unchanged.
